// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, SUB/SRA op encodings and the ALU
// result-mux select codes served by the registered sub_sra_unit slice.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic [3:0] {
    ALU_SEL_ADD  = 4'd0,
    ALU_SEL_SUB  = 4'd1,
    ALU_SEL_AND  = 4'd2,
    ALU_SEL_OR   = 4'd3,
    ALU_SEL_XOR  = 4'd4,
    ALU_SEL_SRA  = 4'd5,
    ALU_SEL_SRL  = 4'd6,
    ALU_SEL_SLL  = 4'd7
  } alu_sel_e;

endpackage

// File: rtl/sra_shifter.sv
// Combinational log barrel shifter: right shifts by 1/2/4/8/16 selected by
// shamt bits, vacated positions filled with sign_fill.
module sra_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sign_fill,
  output logic [WIDTH-1:0]   shifted
);

  logic [WIDTH-1:0] stg [0:SHAMT_W];

  assign stg[0] = data;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign stg[i+1] = shamt[i] ? {{SH{sign_fill}}, stg[i][WIDTH-1:SH]} : stg[i];
  end

  assign shifted = stg[SHAMT_W];

endmodule

// File: rtl/sub_sra_unit.sv
// Registered RV32 SUB/SRA slice for the EX stage: one output register stage,
// full throughput, result and flags hold while no request is accepted.
module sub_sra_unit #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             borrow
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Signed overflow of a - b: operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic [WIDTH:0]   diff_p0;
  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] res_p0;
  logic             ovf_p0;
  logic             brw_p0;
  logic             is_sra_p0;

  // Stage p0: combinational subtract (A + ~B + 1) and barrel shift
  assign diff_p0 = {1'b0, operand_A} + {1'b0, ~operand_B} + {{WIDTH{1'b0}}, 1'b1};

  sra_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_sra_shifter (
    .data      (operand_A),
    .shamt     (operand_B[SHAMT_W-1:0]),
    .sign_fill (operand_A[WIDTH-1]),
    .shifted   (shift_p0)
  );

  assign is_sra_p0 = (op == alu_pkg::OP_SRA);
  assign res_p0    = is_sra_p0 ? shift_p0 : diff_p0[WIDTH-1:0];
  assign ovf_p0    = !is_sra_p0 &&
                     sub_overflow(operand_A[WIDTH-1], operand_B[WIDTH-1], diff_p0[WIDTH-1]);
  assign brw_p0    = !is_sra_p0 && !diff_p0[WIDTH];

  logic [WIDTH-1:0] result_p1;
  logic             vld_p1;
  logic             zero_p1;
  logic             neg_p1;
  logic             ovf_p1;
  logic             brw_p1;

  // Stage p1: output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
      zero_p1   <= 1'b0;
      neg_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
      brw_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= res_p0;
        zero_p1   <= (res_p0 == '0);
        neg_p1    <= res_p0[WIDTH-1];
        ovf_p1    <= ovf_p0;
        brw_p1    <= brw_p0;
      end
    end
  end

  assign result    = result_p1;
  assign out_valid = vld_p1;
  assign zero      = zero_p1;
  assign negative  = neg_p1;
  assign overflow  = ovf_p1;
  assign borrow    = brw_p1;

endmodule

// File: tb/tb_sub_sra_unit.sv
// Directed and back-to-back checks of sub_sra_unit; inputs change and outputs
// are sampled on the falling clock edge.
module tb_sub_sra_unit;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        op;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        borrow;

  int errors = 0;
  int checks = 0;

  sub_sra_unit #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .op        (op),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .borrow    (borrow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic v,
                           input logic z, input logic n, input logic o, input logic b);
    check({tag, ".result"},    result,          r);
    check({tag, ".out_valid"}, 32'(out_valid),  32'(v));
    check({tag, ".zero"},      32'(zero),       32'(z));
    check({tag, ".negative"},  32'(negative),   32'(n));
    check({tag, ".overflow"},  32'(overflow),   32'(o));
    check({tag, ".borrow"},    32'(borrow),     32'(b));
  endtask

  // Reference model built on wide signed arithmetic and >>>.
  task automatic model(input logic o_sra, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ovf, output logic brw);
    longint sd;
    if (o_sra) begin
      r   = $signed(a) >>> b[4:0];
      ovf = 1'b0;
      brw = 1'b0;
    end else begin
      sd  = longint'($signed(a)) - longint'($signed(b));
      r   = a - b;
      ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      brw = (a < b);
    end
  endtask

  // Called on a falling edge: request for one cycle, check on the next falling edge.
  task automatic run_dir(input string tag, input logic o_sra, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic z,
                         input logic n, input logic o, input logic brw);
    op        = o_sra;
    operand_A = a;
    operand_B = b;
    in_valid  = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b0;
    check_out(tag, r, 1'b1, z, n, o, brw);
  endtask

  initial begin
    logic [31:0] er;
    logic        eo, eb;

    RESET     = 1'b1;
    in_valid  = 1'b1;
    op        = 1'b0;
    operand_A = 32'd5;
    operand_B = 32'd1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET    = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("idle.out_valid", 32'(out_valid), 32'd0);

    run_dir("sub_10_3",   1'b0, 32'd10,        32'd3,         32'd7,         0, 0, 0, 0);
    run_dir("sub_0_1",    1'b0, 32'd0,         32'd1,         32'hFFFFFFFF,  0, 1, 0, 1);
    run_dir("sub_min_1",  1'b0, 32'h80000000,  32'd1,         32'h7FFFFFFF,  0, 0, 1, 0);
    run_dir("sub_eq",     1'b0, 32'h1234,      32'h1234,      32'h0,         1, 0, 0, 0);
    run_dir("sub_1_min",  1'b0, 32'd1,         32'h80000000,  32'h80000001,  0, 1, 1, 1);
    run_dir("sra_min_31", 1'b1, 32'h80000000,  32'd31,        32'hFFFFFFFF,  0, 1, 0, 0);
    run_dir("sra_f_4",    1'b1, 32'hF0000000,  32'd4,         32'hFF000000,  0, 1, 0, 0);
    run_dir("sra_7_4",    1'b1, 32'h70000000,  32'd4,         32'h07000000,  0, 0, 0, 0);
    run_dir("sra_sh0",    1'b1, 32'h8BADF00D,  32'h00000020,  32'h8BADF00D,  0, 1, 0, 0);
    run_dir("sra_hi_ign", 1'b1, 32'h12345678,  32'hFFFFFFE8,  32'h00123456,  0, 0, 0, 0);

    // Hold: no request, outputs keep the last result
    @(negedge CLK);
    check_out("hold", 32'h00123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back alternating SUB/SRA, one vector per cycle
    for (int i = 0; i < 100; i++) begin
      op        = i[0];
      operand_A = $urandom;
      operand_B = (i % 10 == 3) ? operand_A : $urandom;
      in_valid  = 1'b1;
      model(op, operand_A, operand_B, er, eo, eb);
      @(negedge CLK);
      check_out($sformatf("b2b%0d", i), er, 1'b1, er == 32'h0, er[31], eo, eb);
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check("b2b_end.out_valid", 32'(out_valid), 32'd0);
    check("b2b_end.result", result, er);

    // Abort: reset right after an accepted request
    op        = 1'b0;
    operand_A = 32'd10;
    operand_B = 32'd3;
    in_valid  = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b0;
    RESET     = 1'b1;
    check("abort.pre_valid", 32'(out_valid), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    check_out("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
